// File: rtl/mips_lite_pkg.sv
// Shared definitions for the MIPS-Lite EX-stage multiply controller.
// State codes are plain 2-bit constants so older netlists and waveform
// decoders that expect fixed encodings keep working.
package mips_lite_pkg;

  // Default datapath width for HI, LO and the multiply operands.
  localparam int WIDTH_DEF = 32;

  // Default iteration-counter width; 2**CNT_W must exceed the width.
  localparam int CNT_W_DEF = 6;

  // Multiply controller state encoding; 2'd3 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : mips_lite_pkg

// File: rtl/ripple_adder_n.sv
// N-bit ripple-carry adder assembled from single-bit full-adder cells.
// The multiply controller reuses one instance for every shift-add step.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Single-bit sum and carry generation.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : full_adder

module ripple_adder_n #(
  parameter int WIDTH = mips_lite_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  // Chain one full-adder cell per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule : ripple_adder_n

// File: rtl/multu_seq_ctrl.sv
// Sequential unsigned multiplier controller for the MIPS-Lite EX stage.
// Implements MULTU as WIDTH shift-add iterations through one shared ripple
// adder, owns the HI/LO registers (MTHI/MTLO writes) and raises a pipeline
// stall when a HI/LO access shows up while a multiply is still iterating.
module multu_seq_ctrl
  import mips_lite_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Count value of the final iteration; that edge also commits HI/LO.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] shift_hi;
  logic [WIDTH-1:0] shift_lo;
  logic             last_iter;
  logic             accept;

  // Multiplier LSB selects whether the multiplicand is added this step.
  always_comb begin
    addend = p_lo[0] ? mcand : '0;
  end

  ripple_adder_n #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (p_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Right-shift {carry, sum, P_lo} by one; the carry lands in the P_hi MSB
  // so the 2*WIDTH-bit product can never overflow.
  always_comb begin
    shift_hi  = {add_cout, add_sum[WIDTH-1:1]};
    shift_lo  = {add_sum[0], p_lo[WIDTH-1:1]};
    last_iter = (count == LAST_CNT);
    accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // Next-state decode; DONE is a single cycle and may chain into a new RUN.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = start ? ST_RUN : ST_IDLE;
      ST_RUN:  next_state = last_iter ? ST_DONE : ST_RUN;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Product, multiplicand and iteration counter; loaded on issue, stepped in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_hi  <= '0;
      p_lo  <= '0;
      mcand <= '0;
      count <= '0;
    end else if (accept) begin
      p_hi  <= '0;
      p_lo  <= dataB;
      mcand <= dataA;
      count <= '0;
    end else if (state == ST_RUN) begin
      p_hi  <= shift_hi;
      p_lo  <= shift_lo;
      count <= count + CNT_W'(1);
    end
  end

  // HI/LO change only at completion or on MT writes outside RUN; RUN-time
  // writes are held off by the stall, so the two never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_RUN) begin
      if (last_iter) begin
        hi_q <= shift_hi;
        lo_q <= shift_lo;
      end
    end else if ((state == ST_IDLE) || (state == ST_DONE)) begin
      if (hi_we) begin
        hi_q <= wdata;
      end
      if (lo_we) begin
        lo_q <= wdata;
      end
    end
  end

  // Status outputs decoded from state; stall also folds in HI/LO requests.
  always_comb begin
    busy  = (state == ST_RUN);
    done  = (state == ST_DONE);
    stall = busy && (hilo_rd || hi_we || lo_we);
    HI    = hi_q;
    LO    = lo_q;
  end

endmodule : multu_seq_ctrl

// File: doc/multu_seq_ctrl.md
Name: multu_seq_ctrl

Overview:
- Sequential unsigned multiply controller for the MIPS-Lite EX stage (MULTU, MTHI/MTLO, and interlock for MFHI/MFLO).
- Shares one WIDTH-bit ripple adder, built from full-adder slices, across WIDTH shift-add iterations.
- Owns the HI/LO registers and raises a pipeline stall when a HI/LO access arrives while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  MULTU issue request
- dataA  in  WIDTH  multiplicand (rs)
- dataB  in  WIDTH  multiplier (rt)
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- hilo_rd  in  1  MFHI/MFLO in EX this cycle
- busy  out  1  multiply iterating
- done  out  1  one-cycle completion pulse
- stall  out  1  pipeline interlock
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at an edge, any state, including mid-multiply):
  - state=IDLE; HI=LO=0; product register=0; count=0.
  - busy=0, done=0, stall=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: start=1 at edge E0 loads P_hi=0, P_lo=dataB, M=dataA, count=0; next state RUN.
  - RUN: one iteration per edge.
    - Each iteration: {c,s}=P_hi+(P_lo[0]?M:0) via the shared adder, carry-in 0.
    - Then {P_hi,P_lo} <= {c,s,P_lo}>>1; count++.
    - On the iteration with count==WIDTH-1, HI/LO are loaded from the shifted result at that same edge; next state DONE.
  - DONE: lasts exactly one cycle.
    - start=1 is accepted exactly as in IDLE (back-to-back issue); otherwise next state IDLE.
- Latency (WIDTH=32):
  - Iterations at edges E1..E32; HI/LO valid after E32.
  - done=1 for the single cycle between E32 and E33.
  - busy=1 from after E0 through E32 (i.e. whenever state==RUN).
- Outputs are registered/decoded from state only:
  - busy = (state==RUN)
  - done = (state==DONE)
  - stall = busy & (hilo_rd | hi_we | lo_we)
- HI/LO change only on reset, at completion, or on an MT write. They are never updated during RUN with partial products.
- start while busy is ignored, with no queuing. The issuing stage must hold until busy=0.
- MT writes:
  - In IDLE/DONE: hi_we loads HI<=wdata and lo_we loads LO<=wdata, applied at the edge.
  - hi_we and lo_we may both be set; both registers then load.
  - In RUN: writes are ignored and stall=1 holds the instruction.
  - MT write and start in the same cycle: the write applies now; the multiply result overwrites HI/LO at completion.
- Arithmetic: unsigned and exact to 2*WIDTH bits; the adder carry-out is shifted into P_hi MSB, so there is no overflow path.
- Completion edge vs MT write: an MT write in RUN is always stalled, so there is no conflict.

Decomposition:
- Shared package mips_lite_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - WIDTH default.
- One sub-module, ripple_adder_n (WIDTH-bit, carry-in/carry-out), built from the existing full-adder cell.
- FSM, counter and product/HI/LO registers stay in multu_seq_ctrl.

Test Plan:
- Reset, then start with dataA=3, dataB=5:
  - busy=1 for 32 cycles; done pulses the cycle after E32.
  - HI=0, LO=15.
- dataA=dataB=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; second pair 80000000*2 -> HI=1, LO=0.
- Start while busy:
  - Start with 7*6; at E10 assert start with 9*9.
  - Ignored: result HI=0, LO=42; busy duration unchanged.
- Interlock during RUN:
  - hilo_rd=1 -> stall=1; hi_we=1 with wdata=DEADBEEF -> stall=1 and HI unchanged.
  - Same hi_we in IDLE -> HI=DEADBEEF next cycle, stall=0.
- Reset mid-operation: rst_n=0 at E16 of a multiply -> next cycle state IDLE, busy=0, done=0, HI=LO=0, and no done pulse follows.
- Back-to-back: start held high through DONE with new operands 2*3 -> second multiply accepted at the DONE edge with no IDLE cycle; LO=6 after 32 more iterations.
